// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding, opcodes,
// ALU operations, mux selects and the opcode/function legality rule.
package proc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_e;

    localparam int unsigned OP_RTYPE = 0;
    localparam int unsigned OP_LW    = 1;
    localparam int unsigned OP_SW    = 2;
    localparam int unsigned OP_ADDI  = 3;
    localparam int unsigned OP_BEQ   = 4;
    localparam int unsigned OP_BNE   = 5;
    localparam int unsigned OP_JMP   = 6;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_SLL = 2'd2,
        ALU_AND = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_REG = 2'd0,
        SRCB_ONE = 2'd1,
        SRCB_IMM = 2'd2
    } alu_src_b_e;

    // R-type function codes map directly onto ALU operations, so only those are legal.
    function automatic logic is_legal(input int unsigned op, input int unsigned fn);
        return (op <= OP_JMP) && ((op != OP_RTYPE) || (fn <= 32'(ALU_AND)));
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> IR/datapath/memory signal bundle; master is the controller side.
interface multicycle_control_unit_if #(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned FUNCT_W  = 4,
    parameter int unsigned ALUOP_W  = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  function_code;
    logic                mem_ready;
    logic                ir_write;
    logic                pc_write;
    logic                pc_write_cond;
    logic                branch_ne;
    logic [1:0]          pc_source;
    logic                reg_dst;
    logic                reg_write;
    logic                mem_req;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUOP_W-1:0]  alu_op;
    logic                illegal_op;
    logic                bus_error;
    logic                halted;

    modport master (
        input  opcode, function_code, mem_ready,
        output ir_write, pc_write, pc_write_cond, branch_ne, pc_source,
               reg_dst, reg_write, mem_req, mem_read, mem_write, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, illegal_op, bus_error, halted
    );

    modport slave (
        output opcode, function_code, mem_ready,
        input  ir_write, pc_write, pc_write_cond, branch_ne, pc_source,
               reg_dst, reg_write, mem_req, mem_read, mem_write, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, illegal_op, bus_error, halted
    );
endinterface

// File: rtl/mem_timeout_counter.sv
// Counts consecutive cycles a memory request waits for ready; expired fires in the
// MEM_TIMEOUT-th waiting cycle. MEM_TIMEOUT=0 never expires.
module mem_timeout_counter #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic expired
);
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;

    // A request leaves its state only on ready or trap, so clearing whenever the
    // wait ends also covers clearing on every state change.
    always_comb begin
        waiting = req & ~ready;
        cnt_d   = waiting ? cnt_q + CNT_W'(1) : '0;
        expired = (MEM_TIMEOUT != 0) && waiting && (cnt_q == CNT_W'(LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle controller: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// enables and muxes, traps illegal instructions and memory timeouts.
module multicycle_control_unit
    import proc_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned FUNCT_W     = 4,
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic                       clk,
    input logic                       rst,
    multicycle_control_unit_if.master bus
);
    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [FUNCT_W-1:0]  funct_q, funct_d;
    logic                illegal_q, illegal_d;
    logic                bus_err_q, bus_err_d;
    logic                expired;

    mem_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.mem_req),
        .ready   (bus.mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            FETCH: begin
                if (expired) begin
                    state_d   = TRAP;
                    bus_err_d = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                opcode_d = bus.opcode;
                funct_d  = bus.function_code;
                if (is_legal(32'(bus.opcode), 32'(bus.function_code))) begin
                    state_d = EXEC;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                case (32'(opcode_q))
                    OP_LW, OP_SW:          state_d = MEM;
                    OP_BEQ, OP_BNE, OP_JMP: state_d = FETCH;
                    default:               state_d = WB;
                endcase
            end
            MEM: begin
                if (expired) begin
                    state_d   = TRAP;
                    bus_err_d = 1'b1;
                end else if (bus.mem_ready) begin
                    state_d = (32'(opcode_q) == OP_LW) ? WB : FETCH;
                end
            end
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            opcode_q  <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Outputs are held at zero while rst is high so an aborted access stops at once.
    always_comb begin
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_source     = PCSRC_ALU;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem_req       = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALUOP_W'(ALU_ADD);
        bus.illegal_op    = 1'b0;
        bus.bus_error     = 1'b0;
        bus.halted        = 1'b0;
        if (!rst) begin
            bus.illegal_op = illegal_q;
            bus.bus_error  = bus_err_q;
            case (state_q)
                FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_ONE;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                DECODE: begin
                    bus.alu_src_b = SRCB_IMM;
                end
                EXEC: begin
                    case (32'(opcode_q))
                        OP_RTYPE: begin
                            bus.alu_src_a = 1'b1;
                            bus.alu_op    = ALUOP_W'(funct_q);
                        end
                        OP_LW, OP_SW, OP_ADDI: begin
                            bus.alu_src_a = 1'b1;
                            bus.alu_src_b = SRCB_IMM;
                        end
                        OP_BEQ, OP_BNE: begin
                            bus.alu_src_a     = 1'b1;
                            bus.alu_op        = ALUOP_W'(ALU_SUB);
                            bus.pc_write_cond = 1'b1;
                            bus.pc_source     = PCSRC_ALUOUT;
                            bus.branch_ne     = (32'(opcode_q) == OP_BNE);
                        end
                        OP_JMP: begin
                            bus.pc_write  = 1'b1;
                            bus.pc_source = PCSRC_JUMP;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_read  = (32'(opcode_q) == OP_LW);
                    bus.mem_write = (32'(opcode_q) == OP_SW);
                end
                WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = (32'(opcode_q) == OP_RTYPE);
                    bus.mem_to_reg = (32'(opcode_q) == OP_LW);
                end
                TRAP: begin
                    bus.halted = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: latency/flag vector table, then a cycle-accurate expected
// trace built from instruction-level rules and compared under random stimulus.
module tb_multicycle_control_unit;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.OPCODE_W(4), .FUNCT_W(4), .ALUOP_W(4)) bus ();

    multicycle_control_unit #(
        .OPCODE_W    (4),
        .FUNCT_W     (4),
        .ALUOP_W     (4),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       illegal_op;
        logic       bus_error;
        logic       halted;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic [3:0] opc;
        logic [3:0] fn;
        outs_t      exp;
        string      tag;
    } cyc_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] fn;
        int         fw;
        int         mw;
        int         lat;
        bit         ill;
        bit         berr;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    cyc_t q[$];

    function automatic outs_t get_outs();
        outs_t o;
        o.ir_write      = bus.ir_write;
        o.pc_write      = bus.pc_write;
        o.pc_write_cond = bus.pc_write_cond;
        o.branch_ne     = bus.branch_ne;
        o.pc_source     = bus.pc_source;
        o.reg_dst       = bus.reg_dst;
        o.reg_write     = bus.reg_write;
        o.mem_req       = bus.mem_req;
        o.mem_read      = bus.mem_read;
        o.mem_write     = bus.mem_write;
        o.mem_to_reg    = bus.mem_to_reg;
        o.alu_src_a     = bus.alu_src_a;
        o.alu_src_b     = bus.alu_src_b;
        o.alu_op        = bus.alu_op;
        o.illegal_op    = bus.illegal_op;
        o.bus_error     = bus.bus_error;
        o.halted        = bus.halted;
        return o;
    endfunction

    task automatic check(input string tag, input outs_t got, input outs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected outputs per instruction step, straight from the controller rules.
    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = '0;
        o.mem_req   = 1'b1;
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'd1;
        o.ir_write  = rdy;
        o.pc_write  = rdy;
        return o;
    endfunction

    function automatic outs_t o_decode();
        outs_t o = '0;
        o.alu_src_b = 2'd2;
        return o;
    endfunction

    function automatic outs_t o_exec(input logic [3:0] op, input logic [3:0] fn);
        outs_t o = '0;
        if (op == 4'd0) begin
            o.alu_src_a = 1'b1;
            o.alu_op    = fn;
        end else if (op >= 4'd1 && op <= 4'd3) begin
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'd2;
        end else if (op == 4'd4 || op == 4'd5) begin
            o.alu_src_a     = 1'b1;
            o.alu_op        = 4'd1;
            o.pc_write_cond = 1'b1;
            o.pc_source     = 2'd1;
            o.branch_ne     = (op == 4'd5);
        end else begin
            o.pc_write  = 1'b1;
            o.pc_source = 2'd2;
        end
        return o;
    endfunction

    function automatic outs_t o_mem(input logic [3:0] op);
        outs_t o = '0;
        o.mem_req   = 1'b1;
        o.mem_read  = (op == 4'd1);
        o.mem_write = (op == 4'd2);
        return o;
    endfunction

    function automatic outs_t o_wb(input logic [3:0] op);
        outs_t o = '0;
        o.reg_write  = 1'b1;
        o.reg_dst    = (op == 4'd0);
        o.mem_to_reg = (op == 4'd1);
        return o;
    endfunction

    function automatic logic [3:0] junk();
        return 4'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    task automatic push(input logic r, input logic rdy, input logic [3:0] opc,
                        input logic [3:0] fn, input outs_t e, input string tag);
        cyc_t c;
        c.rst = r;
        c.rdy = rdy;
        c.opc = opc;
        c.fn  = fn;
        c.exp = e;
        c.tag = tag;
        q.push_back(c);
    endtask

    task automatic push_trap(input bit ill, input int len);
        outs_t o = '0;
        o.halted     = 1'b1;
        o.illegal_op = ill;
        o.bus_error  = !ill;
        for (int i = 0; i < len; i++) push(1'b0, rbit(), junk(), junk(), o, "trap");
        push(1'b1, rbit(), junk(), junk(), '0, "rst_after_trap");
    endtask

    // One memory access: waits below TO then ready, otherwise TO waits then trap.
    task automatic push_access(input int waits, input bit is_fetch, input logic [3:0] op,
                               output bit timed_out);
        int n;
        timed_out = (waits >= int'(TO));
        n = timed_out ? int'(TO) : waits;
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b0, junk(), junk(), is_fetch ? o_fetch(1'b0) : o_mem(op),
                 is_fetch ? "fetch_wait" : "mem_wait");
        if (!timed_out)
            push(1'b0, 1'b1, junk(), junk(), is_fetch ? o_fetch(1'b1) : o_mem(op),
                 is_fetch ? "fetch_done" : "mem_done");
    endtask

    task automatic add_instr(input logic [3:0] op, input logic [3:0] fn,
                             input int fw, input int mw, input int trap_len);
        bit to;
        push_access(fw, 1'b1, op, to);
        if (to) begin
            push_trap(1'b0, trap_len);
            return;
        end
        push(1'b0, rbit(), op, fn, o_decode(), "decode");
        if (op > 4'd6 || (op == 4'd0 && fn > 4'd3)) begin
            push_trap(1'b1, trap_len);
            return;
        end
        push(1'b0, rbit(), junk(), junk(), o_exec(op, fn), "exec");
        if (op == 4'd1 || op == 4'd2) begin
            push_access(mw, 1'b0, op, to);
            if (to) begin
                push_trap(1'b0, trap_len);
                return;
            end
            if (op == 4'd2) return;
        end
        if (op <= 4'd3) push(1'b0, rbit(), junk(), junk(), o_wb(op), "wb");
    endtask

    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            rst               = c.rst;
            bus.mem_ready     = c.rdy;
            bus.opcode        = c.opc;
            bus.function_code = c.fn;
            #1;
            check(c.tag, get_outs(), c.exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.mem_ready = rbit();
        #1;
        check("reset_outputs", get_outs(), '0);
        @(negedge clk);
        rst           = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    localparam int NV = 16;
    vec_t vt[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0]  = '{4'd0, 4'd0, 0, 0, 4,  1'b0, 1'b0};  // R add
        vt[1]  = '{4'd0, 4'd3, 3, 0, 7,  1'b0, 1'b0};  // R and, fetch waits at limit-1
        vt[2]  = '{4'd1, 4'd0, 0, 2, 7,  1'b0, 1'b0};  // lw, 2 mem waits
        vt[3]  = '{4'd1, 4'd5, 3, 3, 11, 1'b0, 1'b0};  // lw, ready on limit cycle
        vt[4]  = '{4'd2, 4'd9, 1, 0, 5,  1'b0, 1'b0};  // sw
        vt[5]  = '{4'd3, 4'd0, 0, 0, 4,  1'b0, 1'b0};  // addi
        vt[6]  = '{4'd4, 4'd0, 0, 0, 3,  1'b0, 1'b0};  // beq
        vt[7]  = '{4'd5, 4'd0, 2, 0, 5,  1'b0, 1'b0};  // bne
        vt[8]  = '{4'd6, 4'd0, 0, 0, 3,  1'b0, 1'b0};  // jmp
        vt[9]  = '{4'd9, 4'd0, 0, 0, 2,  1'b1, 1'b0};  // undefined opcode
        vt[10] = '{4'd7, 4'd0, 0, 0, 2,  1'b1, 1'b0};  // first undefined opcode
        vt[11] = '{4'd0, 4'd7, 1, 0, 3,  1'b1, 1'b0};  // undefined function
        vt[12] = '{4'd0, 4'd4, 0, 0, 2,  1'b1, 1'b0};  // first undefined function
        vt[13] = '{4'd0, 4'd0, 4, 0, 4,  1'b0, 1'b1};  // fetch timeout
        vt[14] = '{4'd1, 4'd0, 0, 4, 7,  1'b0, 1'b1};  // lw timeout
        vt[15] = '{4'd2, 4'd0, 2, 6, 9,  1'b0, 1'b1};  // sw timeout

        bus.opcode        = '0;
        bus.function_code = '0;
        bus.mem_ready     = 1'b0;

        for (int i = 0; i < NV; i++) begin
            int    acc;
            int    wc;
            int    lat;
            bit    seen_ir;
            bit    done;
            outs_t o;
            do_reset();
            bus.opcode        = vt[i].op;
            bus.function_code = vt[i].fn;
            acc = 0; wc = 0; lat = -1; seen_ir = 1'b0; done = 1'b0; o = '0;
            for (int cyc = 0; cyc < 40 && !done; cyc++) begin
                if (cyc > 0) @(negedge clk);
                #1;
                if (bus.mem_req) begin
                    if (wc >= ((acc == 0) ? vt[i].fw : vt[i].mw)) begin
                        bus.mem_ready = 1'b1;
                        wc = 0;
                        acc++;
                    end else begin
                        bus.mem_ready = 1'b0;
                        wc++;
                    end
                end else begin
                    bus.mem_ready = rbit();
                end
                #1;
                o = get_outs();
                if (o.halted || (seen_ir && o.alu_src_b == 2'd1)) begin
                    done = 1'b1;
                    lat  = cyc;
                end
                if (o.ir_write) seen_ir = 1'b1;
            end
            check_int($sformatf("latency[%0d]", i), lat, vt[i].lat);
            check_int($sformatf("flags[%0d]", i), int'({o.illegal_op, o.bus_error, o.halted}),
                      int'({vt[i].ill, vt[i].berr, vt[i].ill | vt[i].berr}));
        end

        // Trap holds for 20 cycles and reset clears the flags.
        q.delete();
        push(1'b1, 1'b0, '0, '0, '0, "rst");
        add_instr(4'd9, 4'd0, 0, 0, 20);
        add_instr(4'd0, 4'd7, 0, 0, 20);
        add_instr(4'd0, 4'd0, 0, 0, 3);
        run_queue();

        for (int n = 0; n < 150; n++) begin
            int         r;
            int         fw;
            int         mw;
            logic [3:0] op;
            logic [3:0] fn;
            r = int'($urandom_range(0, 19));
            if (r < 17) begin
                op = 4'(r % 7);
                fn = (op == 4'd0) ? 4'($urandom_range(0, 3)) : junk();
            end else if (r == 17) begin
                op = 4'($urandom_range(7, 15));
                fn = junk();
            end else begin
                op = 4'd0;
                fn = 4'($urandom_range(4, 15));
            end
            fw = ($urandom_range(0, 9) == 0) ? int'(TO + $urandom_range(0, 2)) : int'($urandom_range(0, TO - 1));
            mw = ($urandom_range(0, 5) == 0) ? int'(TO + $urandom_range(0, 2)) : int'($urandom_range(0, TO - 1));
            add_instr(op, fn, fw, mw, 3);
            run_queue();
        end

        // Reset during a stalled store must drop the write strobe immediately.
        push(1'b1, 1'b0, junk(), junk(), '0, "rst");
        push(1'b0, 1'b1, junk(), junk(), o_fetch(1'b1), "sw_fetch");
        push(1'b0, rbit(), 4'd2, 4'd0, o_decode(), "sw_decode");
        push(1'b0, rbit(), junk(), junk(), o_exec(4'd2, 4'd0), "sw_exec");
        push(1'b0, 1'b0, junk(), junk(), o_mem(4'd2), "sw_mem");
        run_queue();
        #2;
        rst = 1'b1;
        #1;
        check("sw_abort_async", get_outs(), '0);
        @(negedge clk);
        rst           = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("post_abort_fetch", get_outs(), o_fetch(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
